// File: rtl/scfifo_param_if.sv
// scfifo_param_if -- bundle of the FIFO request/response signals.
//   master : producer/consumer side (drives sclr, datain, write, read)
//   slave  : FIFO side (drives q, empty, full, usedw, thresholds, error flags)
interface scfifo_param_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
);
  logic              sclr;
  logic [DWIDTH-1:0] datain;
  logic              write;
  logic              read;
  logic [DWIDTH-1:0] q;
  logic              empty;
  logic              full;
  logic [AWIDTH:0]   usedw;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output sclr, datain, write, read,
    input  q, empty, full, usedw, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  sclr, datain, write, read,
    output q, empty, full, usedw, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/scfifo_param.sv
// scfifo_param -- parametrised single-clock FIFO, depth 2^AWIDTH.
// Ports:
//   clk      : single clock, all state changes on the rising edge
//   areset_n : asynchronous active-low reset
//   fifo     : scfifo_param_if.slave
//              in : sclr (sync clear), datain, write, read
//              out: q, empty, full, usedw, almost_full, almost_empty,
//                   overflow (sticky), underflow (sticky)
// SHOWAHEAD=0 gives a registered q with 1-cycle read latency; SHOWAHEAD=1
// presents the head word on q while not empty and read acknowledges it.
module scfifo_param #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2,
  parameter int SHOWAHEAD = 0
) (
  input logic           clk,
  input logic           areset_n,
  scfifo_param_if.slave fifo
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_V   = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AFULL_V  = AFULL_TH[AWIDTH:0];
  localparam logic [AWIDTH:0] AEMPTY_V = AEMPTY_TH[AWIDTH:0];

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic [DWIDTH-1:0] q_q;
  logic              empty_q, full_q, afull_q, aempty_q;
  logic              overflow_q, underflow_q;
  logic              wr_acc, rd_acc;

  // Clear wins over both requests; a read frees a slot even when full.
  assign wr_acc = fifo.write & (~full_q | fifo.read) & ~fifo.sclr;
  assign rd_acc = fifo.read & ~empty_q & ~fifo.sclr;

  always_comb begin
    usedw_d = usedw_q;
    if (fifo.sclr) begin
      usedw_d = '0;
    end else begin
      usedw_d = usedw_q + (AWIDTH+1)'(wr_acc) - (AWIDTH+1)'(rd_acc);
    end
  end

  // Storage array carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= fifo.datain;
    end
  end

  // Flags are registered from the next count so they never see input glitches.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      q_q         <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      usedw_q  <= usedw_d;
      empty_q  <= (usedw_d == '0);
      full_q   <= (usedw_d == FULL_V);
      afull_q  <= (usedw_d >= AFULL_V);
      aempty_q <= (usedw_d <= AEMPTY_V);
      if (fifo.sclr) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        q_q         <= '0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
        end
        if (rd_acc) begin
          rd_ptr_q <= rd_ptr_q + AWIDTH'(1);
          q_q      <= mem_q[rd_ptr_q];
        end
        if (fifo.write & full_q & ~fifo.read) begin
          overflow_q <= 1'b1;
        end
        if (fifo.read & empty_q) begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

  // Show-ahead output is forced to 0 while empty so reset leaves q at 0.
  assign fifo.q = (SHOWAHEAD != 0) ? (empty_q ? '0 : mem_q[rd_ptr_q]) : q_q;

  assign fifo.empty        = empty_q;
  assign fifo.full         = full_q;
  assign fifo.usedw        = usedw_q;
  assign fifo.almost_full  = afull_q;
  assign fifo.almost_empty = aempty_q;
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

endmodule

// File: tb/tb_scfifo_param.sv
module tb_scfifo_param;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  scfifo_param_if #(.DWIDTH(8), .AWIDTH(3)) ifa ();
  scfifo_param_if #(.DWIDTH(8), .AWIDTH(3)) ifb ();

  scfifo_param #(.DWIDTH(8), .AWIDTH(3), .AFULL_TH(6), .AEMPTY_TH(2), .SHOWAHEAD(0))
    u_norm (.clk(clk), .areset_n(areset_n), .fifo(ifa.slave));

  scfifo_param #(.DWIDTH(8), .AWIDTH(3), .AFULL_TH(6), .AEMPTY_TH(2), .SHOWAHEAD(1))
    u_sa (.clk(clk), .areset_n(areset_n), .fifo(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int uw, input logic [7:0] qv,
                       input logic ovf, input logic unf);
    chk({tag, ".usedw"}, 32'(ifa.usedw), 32'(uw));
    chk({tag, ".q"}, 32'(ifa.q), 32'(qv));
    chk({tag, ".empty"}, 32'(ifa.empty), 32'(uw == 0));
    chk({tag, ".full"}, 32'(ifa.full), 32'(uw == 8));
    chk({tag, ".afull"}, 32'(ifa.almost_full), 32'(uw >= 6));
    chk({tag, ".aempty"}, 32'(ifa.almost_empty), 32'(uw <= 2));
    chk({tag, ".ovf"}, 32'(ifa.overflow), 32'(ovf));
    chk({tag, ".unf"}, 32'(ifa.underflow), 32'(unf));
  endtask

  initial begin
    ifa.sclr = 0; ifa.write = 0; ifa.read = 0; ifa.datain = '0;
    ifb.sclr = 0; ifb.write = 0; ifb.read = 0; ifb.datain = '0;

    // Reset then idle
    tick(); tick();
    areset_n = 1'b1;
    tick(); tick();
    chk_a("reset", 0, 8'h00, 0, 0);
    chk("reset_sa.empty", 32'(ifb.empty), 32'd1);
    chk("reset_sa.q", 32'(ifb.q), 32'h00);

    // Fill with 0x31..0x38
    for (int i = 0; i < 8; i++) begin
      ifa.write = 1; ifa.datain = 8'(8'h31 + i);
      tick();
      chk_a($sformatf("fill%0d", i), i + 1, 8'h00, 0, 0);
    end

    // Overflow: write while full, no read
    ifa.datain = 8'h39;
    tick();
    ifa.write = 0;
    chk_a("ovf", 8, 8'h00, 1, 0);

    // Drain in normal mode
    for (int i = 0; i < 8; i++) begin
      ifa.read = 1;
      tick();
      chk_a($sformatf("drain%0d", i), 7 - i, 8'(8'h31 + i), 1, 0);
    end

    // Underflow: read while empty, q holds
    tick();
    ifa.read = 0;
    chk_a("unf", 0, 8'h38, 1, 1);

    // Synchronous clear of error flags and q
    ifa.sclr = 1;
    tick();
    ifa.sclr = 0;
    chk_a("sclr1", 0, 8'h00, 0, 0);

    // Refill and do simultaneous read/write while full
    for (int i = 0; i < 8; i++) begin
      ifa.write = 1; ifa.datain = 8'(8'h31 + i);
      tick();
    end
    chk_a("refill", 8, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ifa.write = 1; ifa.read = 1; ifa.datain = 8'(8'h40 + i);
      tick();
      chk_a($sformatf("rw%0d", i), 8, 8'(8'h31 + i), 0, 0);
    end
    ifa.write = 0;
    for (int i = 0; i < 8; i++) begin
      ifa.read = 1;
      tick();
      chk_a($sformatf("rwdrain%0d", i), 7 - i,
            (i < 4) ? 8'(8'h35 + i) : 8'(8'h40 + i - 4), 0, 0);
    end

    // Read/write together while empty: write accepted, read rejected
    ifa.write = 1; ifa.read = 1; ifa.datain = 8'h5A;
    tick();
    ifa.write = 0; ifa.read = 0;
    chk_a("rw_empty", 1, 8'h43, 0, 1);

    // Build usedw=5 with overflow also set, then clear mid-stream
    for (int i = 0; i < 8; i++) begin
      ifa.write = 1; ifa.datain = 8'(8'h50 + i);
      tick();
    end
    ifa.write = 0;
    chk_a("set_ovf", 8, 8'h43, 1, 1);
    ifa.read = 1;
    tick(); tick(); tick();
    ifa.read = 0;
    chk_a("used5", 5, 8'h51, 1, 1);
    ifa.sclr = 1; ifa.write = 1; ifa.read = 1; ifa.datain = 8'hEE;
    tick();
    ifa.sclr = 0; ifa.write = 0; ifa.read = 0;
    chk_a("sclr2", 0, 8'h00, 0, 0);

    // Show-ahead: word visible without read
    ifb.write = 1; ifb.datain = 8'hA5;
    tick();
    ifb.write = 0;
    chk("sa_a5.q", 32'(ifb.q), 32'hA5);
    chk("sa_a5.empty", 32'(ifb.empty), 32'd0);
    tick();
    chk("sa_hold.q", 32'(ifb.q), 32'hA5);
    ifb.read = 1;
    tick();
    ifb.read = 0;
    chk("sa_rd.empty", 32'(ifb.empty), 32'd1);
    chk("sa_rd.usedw", 32'(ifb.usedw), 32'd0);
    ifb.write = 1; ifb.datain = 8'h11;
    tick();
    ifb.datain = 8'h22;
    tick();
    ifb.write = 0;
    chk("sa_two.q", 32'(ifb.q), 32'h11);
    ifb.read = 1;
    tick();
    ifb.read = 0;
    chk("sa_next.q", 32'(ifb.q), 32'h22);
    chk("sa_next.usedw", 32'(ifb.usedw), 32'd1);

    // Async reset mid-write with q nonzero
    ifa.write = 1; ifa.datain = 8'h77;
    tick(); tick();
    ifa.write = 0; ifa.read = 1;
    tick();
    ifa.read = 0; ifa.write = 1; ifa.datain = 8'h78;
    chk_a("pre_rst", 1, 8'h77, 0, 0);
    #2;
    areset_n = 1'b0;
    #1;
    chk_a("async_rst", 0, 8'h00, 0, 0);
    chk("async_rst_sa.empty", 32'(ifb.empty), 32'd1);
    chk("async_rst_sa.usedw", 32'(ifb.usedw), 32'd0);
    ifa.write = 0;
    tick();
    areset_n = 1'b1;
    tick();
    chk_a("post_rst", 0, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
